// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shifter arbiter slice.
package shift_arb_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned REQ_ID_W = 1;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    // Response slot occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [1:0]        op;
        logic [CNT_W-1:0]  cnt;
        logic [DATA_W-1:0] data;
    } shift_req_t;

endpackage

// File: rtl/shifter_arb_if.sv
// Requester and response channels of the shared-shifter arbiter.
interface shifter_arb_if;
    import shift_arb_pkg::*;

    logic                req0_valid;
    logic                req0_ready;
    logic [DATA_W-1:0]   req0_in;
    logic [CNT_W-1:0]    req0_cnt;
    logic [1:0]          req0_op;

    logic                req1_valid;
    logic                req1_ready;
    logic [DATA_W-1:0]   req1_in;
    logic [CNT_W-1:0]    req1_cnt;
    logic [1:0]          req1_op;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_data;
    logic [REQ_ID_W-1:0] rsp_id;

    modport slave (
        input  req0_valid, req0_in, req0_cnt, req0_op,
        input  req1_valid, req1_in, req1_cnt, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req0_valid, req0_in, req0_cnt, req0_op,
        output req1_valid, req1_in, req1_cnt, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/shifter_arb_rr_arb2.sv
// Two-way round-robin arbiter; pointer names the requester winning a tie.
module rr_arb2 #(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic r_ptr;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req[0] && (!req[1] || !r_ptr)) begin
                grant[0] = 1'b1;
            end else if (req[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'(PRIO_INIT);
        end else if (grant[0]) begin
            r_ptr <= 1'b1;
        end else if (grant[1]) begin
            r_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/shifter_arb_shift16.sv
// 16-bit barrel shifter: rotate/logical shift left/right by 0..15.
module shift16
    import shift_arb_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic [CNT_W-1:0]  i_cnt,
    input  logic [1:0]        i_op,
    output logic [DATA_W-1:0] o_data
);

    logic [2*DATA_W-1:0] w_dbl_l;
    logic [2*DATA_W-1:0] w_dbl_r;

    // Rotates fall out of shifting the operand concatenated with itself
    assign w_dbl_l = {i_data, i_data} << i_cnt;
    assign w_dbl_r = {i_data, i_data} >> i_cnt;

    always_comb begin
        o_data = i_data;
        case (i_op)
            OP_ROL:  o_data = w_dbl_l[2*DATA_W-1:DATA_W];
            OP_SLL:  o_data = i_data << i_cnt;
            OP_ROR:  o_data = w_dbl_r[DATA_W-1:0];
            OP_SRL:  o_data = i_data >> i_cnt;
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/shifter_arb.sv
// Arbitrates two requesters onto one barrel shifter with a registered response slot.
// Optional SHIFT_ARB_STATS_EN adds saturating grant/stall counters.
module shifter_arb #(
    parameter int unsigned PRIO_INIT = 0
`ifdef SHIFT_ARB_STATS_EN
    , parameter int unsigned STATS_W = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    shifter_arb_if.slave       bus
`ifdef SHIFT_ARB_STATS_EN
    , output logic [STATS_W-1:0] grant_cnt0
    , output logic [STATS_W-1:0] grant_cnt1
    , output logic [STATS_W-1:0] stall_cnt
`endif
);
    import shift_arb_pkg::*;

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [REQ_ID_W-1:0] r_id;
    logic [REQ_ID_W-1:0] w_id_nxt;

    logic                w_slot_free;
    logic                w_enable;
    logic                w_accept;
    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    shift_req_t          w_sel;
    logic [DATA_W-1:0]   w_shift;

    assign w_slot_free = (r_state == ST_EMPTY) || bus.rsp_ready;
    assign w_enable    = w_slot_free && !rst;
    assign w_req       = {bus.req1_valid, bus.req0_valid};
    assign w_accept    = |w_grant;

    rr_arb2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (w_req),
        .enable (w_enable),
        .grant  (w_grant)
    );

    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];

    assign w_sel = w_grant[1]
        ? shift_req_t'{op: bus.req1_op, cnt: bus.req1_cnt, data: bus.req1_in}
        : shift_req_t'{op: bus.req0_op, cnt: bus.req0_cnt, data: bus.req0_in};

    shift16 u_shift (
        .i_data (w_sel.data),
        .i_cnt  (w_sel.cnt),
        .i_op   (w_sel.op),
        .o_data (w_shift)
    );

    // Slot next-state; accept while draining refills without a bubble
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_id_nxt    = r_id;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_data_nxt  = w_shift;
                    w_id_nxt    = REQ_ID_W'(w_grant[1]);
                end
            end
            ST_FULL: begin
                if (w_accept) begin
                    w_data_nxt  = w_shift;
                    w_id_nxt    = REQ_ID_W'(w_grant[1]);
                end else if (bus.rsp_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_id    <= w_id_nxt;
        end
    end

    assign bus.rsp_valid = (r_state == ST_FULL);
    assign bus.rsp_data  = r_data;
    assign bus.rsp_id    = r_id;

`ifdef SHIFT_ARB_STATS_EN
    logic               w_stall;
    logic [STATS_W-1:0] r_gcnt0;
    logic [STATS_W-1:0] r_gcnt1;
    logic [STATS_W-1:0] r_scnt;

    assign w_stall = (r_state == ST_FULL) && !bus.rsp_ready;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gcnt0 <= '0;
            r_gcnt1 <= '0;
            r_scnt  <= '0;
        end else begin
            if (w_grant[0] && !(&r_gcnt0)) r_gcnt0 <= r_gcnt0 + STATS_W'(1);
            if (w_grant[1] && !(&r_gcnt1)) r_gcnt1 <= r_gcnt1 + STATS_W'(1);
            if (w_stall    && !(&r_scnt))  r_scnt  <= r_scnt  + STATS_W'(1);
        end
    end

    assign grant_cnt0 = r_gcnt0;
    assign grant_cnt1 = r_gcnt1;
    assign stall_cnt  = r_scnt;
`endif

endmodule

// File: tb/tb_shifter_arb.sv
// Self-checking bench for shifter_arb: cycle model plus directed literal checks.
module tb_shifter_arb;

    localparam int TB_PRIO = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shifter_arb_if bus();

`ifdef SHIFT_ARB_STATS_EN
    logic [1:0] grant_cnt0, grant_cnt1, stall_cnt;
    shifter_arb #(.PRIO_INIT(TB_PRIO), .STATS_W(2)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt)
    );
`else
    shifter_arb #(.PRIO_INIT(TB_PRIO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference shifter: one bit position per iteration
    function automatic logic [15:0] ref_shift(logic [15:0] d, logic [3:0] c, logic [1:0] op);
        logic [15:0] r;
        r = d;
        for (int k = 0; k < int'(c); k++) begin
            case (op)
                2'b00: r = {r[14:0], r[15]};
                2'b01: r = {r[14:0], 1'b0};
                2'b10: r = {r[0], r[15:1]};
                default: r = {1'b0, r[15:1]};
            endcase
        end
        return r;
    endfunction

    // Model state: response slot and round-robin pointer
    bit          m_valid = 1'b0;
    logic [15:0] m_data  = '0;
    int          m_id    = 0;
    int          m_ptr   = TB_PRIO;
    bit          started = 1'b0;

    // Returns 0/1 for the requester that must be granted, 2 for none
    function automatic int exp_grant();
        if (rst) return 2;
        if (m_valid && !bus.rsp_ready) return 2;
        if (bus.req0_valid && bus.req1_valid) return m_ptr;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return 2;
    endfunction

    always @(posedge clk) begin
        int g;
        started = 1'b1;
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = TB_PRIO;
        end else begin
            g = exp_grant();
            if (g == 0) begin
                m_data = ref_shift(bus.req0_in, bus.req0_cnt, bus.req0_op);
                m_id = 0; m_valid = 1'b1; m_ptr = 1;
            end else if (g == 1) begin
                m_data = ref_shift(bus.req1_in, bus.req1_cnt, bus.req1_op);
                m_id = 1; m_valid = 1'b1; m_ptr = 0;
            end else if (!m_valid || bus.rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        if (started) begin
            g = exp_grant();
            chk("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
            chk("rsp_valid",  32'(bus.rsp_valid),  32'(m_valid));
            if (m_valid || rst) begin
                chk("rsp_data", 32'(bus.rsp_data), 32'(m_data));
                chk("rsp_id",   32'(bus.rsp_id),   32'(m_id));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(bit v, logic [15:0] d, logic [3:0] c, logic [1:0] op);
        bus.req0_valid = v; bus.req0_in = d; bus.req0_cnt = c; bus.req0_op = op;
    endtask

    task automatic drive1(bit v, logic [15:0] d, logic [3:0] c, logic [1:0] op);
        bus.req1_valid = v; bus.req1_in = d; bus.req1_cnt = c; bus.req1_op = op;
    endtask

    typedef struct {
        logic [15:0] din;
        logic [3:0]  cnt;
        logic [1:0]  op;
        logic [15:0] exp;
    } vec_t;

    vec_t sweep [8] = '{
        '{16'h8000, 4'd15, 2'b11, 16'h0001},
        '{16'h0001, 4'd1,  2'b10, 16'h8000},
        '{16'hABCD, 4'd8,  2'b00, 16'hCDAB},
        '{16'h8001, 4'd1,  2'b01, 16'h0002},
        '{16'h1234, 4'd0,  2'b00, 16'h1234},
        '{16'h1234, 4'd0,  2'b01, 16'h1234},
        '{16'h1234, 4'd0,  2'b10, 16'h1234},
        '{16'h1234, 4'd0,  2'b11, 16'h1234}
    };

    initial begin
        drive0(1'b1, 16'h5555, 4'd3, 2'b00);
        drive1(1'b1, 16'hAAAA, 4'd3, 2'b00);
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_data",  32'(bus.rsp_data),  32'h0);
        chk("reset ready0",    32'(bus.req0_ready), 32'd0);
        drive0(1'b0, '0, '0, '0);
        drive1(1'b0, '0, '0, '0);
        rst = 1'b0;
        step();

        // Single requester, rotate left by one
        drive0(1'b1, 16'h8001, 4'd1, 2'b00);
        #1;
        chk("t1 ready0", 32'(bus.req0_ready), 32'd1);
        step();
        drive0(1'b0, '0, '0, '0);
        chk("t1 rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1 rsp_data",  32'(bus.rsp_data),  32'h0003);
        chk("t1 rsp_id",    32'(bus.rsp_id),    32'd0);

        // Round-robin alternation from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive0(1'b1, 16'h00F0, 4'd4, 2'b01);
        drive1(1'b1, 16'h0F00, 4'd4, 2'b11);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t2 rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("t2 rsp_id",    32'(bus.rsp_id),    32'(i % 2));
            chk("t2 rsp_data",  32'(bus.rsp_data),  (i % 2 == 0) ? 32'h0F00 : 32'h00F0);
        end
        drive0(1'b0, '0, '0, '0);
        drive1(1'b0, '0, '0, '0);

        // Backpressure holds the result and blocks the queued request
        drive1(1'b1, 16'h1234, 4'd4, 2'b01);
        step();
        chk("t3 rsp_data", 32'(bus.rsp_data), 32'h2340);
        drive1(1'b0, '0, '0, '0);
        drive0(1'b1, 16'hABCD, 4'd8, 2'b00);
        bus.rsp_ready = 1'b0;
        #1;
        chk("t3 ready0 stalled", 32'(bus.req0_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3 hold valid", 32'(bus.rsp_valid), 32'd1);
            chk("t3 hold data",  32'(bus.rsp_data),  32'h2340);
            chk("t3 hold id",    32'(bus.rsp_id),    32'd1);
            chk("t3 ready0",     32'(bus.req0_ready), 32'd0);
            chk("t3 ready1",     32'(bus.req1_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("t3 drain accept", 32'(bus.req0_ready), 32'd1);
        step();
        drive0(1'b0, '0, '0, '0);
        chk("t3 new valid", 32'(bus.rsp_valid), 32'd1);
        chk("t3 new data",  32'(bus.rsp_data),  32'hCDAB);
        chk("t3 new id",    32'(bus.rsp_id),    32'd0);

        // Opcode sweep, including zero shift counts
        for (int i = 0; i < 8; i++) begin
            drive0(1'b1, sweep[i].din, sweep[i].cnt, sweep[i].op);
            step();
            chk("t4 sweep", 32'(bus.rsp_data), 32'(sweep[i].exp));
        end
        drive0(1'b0, '0, '0, '0);
        step();
        chk("t4 idle valid", 32'(bus.rsp_valid), 32'd0);

        // Reset during backpressure discards the result and re-arms the pointer
        drive1(1'b1, 16'h00FF, 4'd4, 2'b10);
        step();
        chk("t5 ror data", 32'(bus.rsp_data), 32'hF00F);
        drive1(1'b0, '0, '0, '0);
        bus.rsp_ready = 1'b0;
        step();
        rst = 1'b1;
        drive0(1'b1, 16'h0001, 4'd2, 2'b01);
        drive1(1'b1, 16'h0001, 4'd3, 2'b01);
        step();
        chk("t5 rst valid",  32'(bus.rsp_valid),  32'd0);
        chk("t5 rst data",   32'(bus.rsp_data),   32'h0);
        chk("t5 rst ready1", 32'(bus.req1_ready), 32'd0);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("t5 prio ready0", 32'(bus.req0_ready), 32'd1);
        chk("t5 prio ready1", 32'(bus.req1_ready), 32'd0);
        step();
        chk("t5 first id",   32'(bus.rsp_id),   32'd0);
        chk("t5 first data", 32'(bus.rsp_data), 32'h0004);
        step();
        chk("t5 second id",   32'(bus.rsp_id),   32'd1);
        chk("t5 second data", 32'(bus.rsp_data), 32'h0008);
        drive0(1'b0, '0, '0, '0);
        drive1(1'b0, '0, '0, '0);
        step();

`ifdef SHIFT_ARB_STATS_EN
        // Two-bit counters saturate at 3
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive0(1'b1, 16'h0F0F, 4'd1, 2'b00);
        repeat (5) step();
        drive0(1'b0, '0, '0, '0);
        bus.rsp_ready = 1'b0;
        repeat (2) step();
        chk("t6 grant_cnt0", 32'(grant_cnt0), 32'd3);
        chk("t6 grant_cnt1", 32'(grant_cnt1), 32'd0);
        chk("t6 stall_cnt",  32'(stall_cnt),  32'd2);
        bus.rsp_ready = 1'b1;
        step();
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
